// File: rtl/tile_pkg.sv
// Shared widths and fetch-FSM encoding for the tile ROM fetch controller.
package tile_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_WIDTH = 8;
    localparam int ROW_BITS   = 3;
    localparam int TILE_BITS  = ADDR_WIDTH - ROW_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/tile_fetch_ctrl_if.sv
// Tile-code handshake, tile ROM bus and pixel stream of the fetch controller.
interface tile_fetch_ctrl_if;
    import tile_pkg::*;

    logic                  tile_valid;
    logic                  tile_ready;
    logic [TILE_BITS-1:0]  tile_code;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_rdata;
    logic                  pix_valid;
    logic                  pix_ready;
    logic                  pix_bit;
    logic                  underrun;

    // master: tile-map source, ROM and colour stage around the controller
    modport master (
        output tile_valid, tile_code, rom_rdata, pix_ready,
        input  tile_ready, rom_addr, pix_valid, pix_bit, underrun
    );

    modport slave (
        input  tile_valid, tile_code, rom_rdata, pix_ready,
        output tile_ready, rom_addr, pix_valid, pix_bit, underrun
    );

endinterface

// File: rtl/tile_shifter.sv
// Parallel-load, MSB-first pixel serialiser with a valid/ready output.
module tile_shifter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  pix_ready,
    output logic                  pix_valid,
    output logic                  pix_bit,
    output logic                  load_ok
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         count;
    logic                  valid;

    // A new row may enter when empty or as the last bit leaves.
    assign load_ok   = !valid || (pix_ready && count == LAST);
    assign pix_valid = valid;
    assign pix_bit   = shift_reg[DATA_WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            count     <= '0;
            valid     <= 1'b0;
        end else if (flush) begin
            shift_reg <= '0;
            count     <= '0;
            valid     <= 1'b0;
        end else if (load_en) begin
            shift_reg <= load_data;
            count     <= '0;
            valid     <= 1'b1;
        end else if (valid && pix_ready) begin
            if (count == LAST) begin
                valid <= 1'b0;
                count <= '0;
            end else begin
                shift_reg <= {shift_reg[DATA_WIDTH-2:0], 1'b0};
                count     <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_fetch_ctrl.sv
// Tile ROM fetch sequencer: handshakes tile codes, prefetches one row ahead,
// and feeds the serialiser so consecutive tiles stream without bubbles.
module tile_fetch_ctrl #(
    parameter int ADDR_WIDTH = tile_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = tile_pkg::DATA_WIDTH,
    parameter int ROW_BITS   = tile_pkg::ROW_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                line_start,
    input  logic [ROW_BITS-1:0] row,
    tile_fetch_ctrl_if.slave    bus
);
    import tile_pkg::*;
    localparam int TILE_BITS = ADDR_WIDTH - ROW_BITS;

    fetch_state_e          state, next_state;
    logic [ROW_BITS-1:0]   row_q;
    logic [TILE_BITS-1:0]  code;
    logic [DATA_WIDTH-1:0] next_buf;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  next_valid, keep, ready, take;
    logic                  load_ok, load_en, pix_valid;
    logic                  first_seen, underrun;

    assign code = bus.tile_code;

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = rst_n && !next_valid && !line_start;
                if (bus.tile_valid && ready) next_state = ST_ADDR;
            end
            ST_ADDR: next_state = ST_DATA;
            ST_DATA: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
        if (line_start) next_state = ST_IDLE;
    end

    assign take = bus.tile_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            row_q    <= '0;
        end else begin
            if (take)       rom_addr <= {code, row_q};
            if (line_start) row_q    <= row;
        end
    end

    // Buffer still occupied after this cycle's load, if any.
    assign load_en = load_ok && next_valid;
    assign keep    = next_valid && !load_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_buf   <= '0;
            next_valid <= 1'b0;
        end else if (line_start) begin
            next_valid <= 1'b0;
        end else if (state == ST_DATA && !keep) begin
            next_buf   <= bus.rom_rdata;
            next_valid <= 1'b1;
        end else begin
            next_valid <= keep;
        end
    end

    // Underrun only counts once the colour stage has taken a pixel this line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_seen <= 1'b0;
            underrun   <= 1'b0;
        end else if (line_start) begin
            first_seen <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (pix_valid && bus.pix_ready)               first_seen <= 1'b1;
            if (first_seen && bus.pix_ready && !pix_valid) underrun   <= 1'b1;
        end
    end

    tile_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (line_start),
        .load_en   (load_en),
        .load_data (next_buf),
        .pix_ready (bus.pix_ready),
        .pix_valid (pix_valid),
        .pix_bit   (bus.pix_bit),
        .load_ok   (load_ok)
    );

    assign bus.tile_ready = ready;
    assign bus.rom_addr   = rom_addr;
    assign bus.pix_valid  = pix_valid;
    assign bus.underrun   = underrun;

    // IDLE only accepts with an empty buffer, so DATA never finds it full.
    assert property (@(posedge clk) disable iff (!rst_n) !(state == ST_DATA && next_valid));

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Bench for tile_fetch_ctrl: ROM model, offered-tile queue and expected pixel stream.
module tb_tile_fetch_ctrl;
    import tile_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                line_start = 1'b0;
    logic [ROW_BITS-1:0] row = '0;

    tile_fetch_ctrl_if bus();

    tile_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .row        (row),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [DATA_WIDTH-1:0] rom_mem [0:(1<<ADDR_WIDTH)-1];
    always @(posedge clk) bus.rom_rdata <= rom_mem[bus.rom_addr];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    bit got[$];
    bit exp[$];
    logic [TILE_BITS-1:0] offer[$];

    // One clock: present the head of the offer queue, log handshakes and consumed pixels.
    task automatic cyc();
        bus.tile_valid = (offer.size() > 0);
        if (offer.size() > 0) bus.tile_code = offer[0];
        #1;
        if (bus.tile_valid && bus.tile_ready) begin
            hs_cnt++;
            void'(offer.pop_front());
        end
        if (bus.pix_valid && bus.pix_ready) got.push_back(bus.pix_bit);
        @(negedge clk);
    endtask

    task automatic add_exp(input logic [TILE_BITS-1:0] c, input logic [ROW_BITS-1:0] r);
        logic [DATA_WIDTH-1:0] d;
        d = rom_mem[{c, r}];
        for (int b = DATA_WIDTH-1; b >= 0; b--) exp.push_back(d[b]);
    endtask

    task automatic new_line(input logic [ROW_BITS-1:0] r);
        offer.delete();
        line_start = 1'b1;
        row = r;
        cyc();
        line_start = 1'b0;
        got.delete();
        exp.delete();
    endtask

    task automatic test_reset();
        checks++; if (bus.rom_addr !== '0) begin failures++; $display("FAIL reset_rom_addr got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.tile_ready !== 1'b0) begin failures++; $display("FAIL reset_tile_ready got=%0b exp=0", bus.tile_ready); end
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%0b exp=0", bus.pix_valid); end
        checks++; if (bus.pix_bit !== 1'b0) begin failures++; $display("FAIL reset_pix_bit got=%0b exp=0", bus.pix_bit); end
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%0b exp=0", bus.underrun); end
    endtask

    task automatic test_single();
        int gaps;
        int bad_ur;
        new_line(3'd2);
        bus.pix_ready = 1'b1;
        offer.push_back(4'd3);
        add_exp(4'd3, 3'd2);
        #1;
        checks++; if (bus.tile_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b exp=1", bus.tile_ready); end
        cyc();
        checks++; if (bus.rom_addr !== 7'h1A) begin failures++; $display("FAIL single_rom_addr got=%0h exp=1a", bus.rom_addr); end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (bus.pix_valid !== (k == 3)) begin
                failures++; $display("FAIL single_latency[%0d] got=%0b exp=%0b", k, bus.pix_valid, (k == 3));
            end
        end
        gaps = 0;
        bad_ur = 0;
        repeat (DATA_WIDTH) begin
            if (bus.pix_valid !== 1'b1) gaps++;
            if (bus.underrun !== 1'b0) bad_ur++;
            cyc();
        end
        checks++; if (gaps != 0) begin failures++; $display("FAIL single_gaps got=%0d exp=0", gaps); end
        checks++; if (bad_ur != 0) begin failures++; $display("FAIL single_early_underrun got=%0d exp=0", bad_ur); end
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL single_fall got=%0b exp=0", bus.pix_valid); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL single_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL single_bit[%0d] got=%0b exp=%0b", i, got[i], exp[i]); end
        end
        cyc(); cyc();
        checks++; if (bus.underrun !== 1'b1) begin failures++; $display("FAIL single_underrun got=%0b exp=1", bus.underrun); end
    endtask

    task automatic test_back_to_back();
        int first, last, ones, bad_ur, hs0;
        new_line(3'd2);
        bus.pix_ready = 1'b1;
        offer.push_back(4'd3); offer.push_back(4'd5);
        add_exp(4'd3, 3'd2); add_exp(4'd5, 3'd2);
        hs0 = hs_cnt;
        first = -1; last = -1; ones = 0; bad_ur = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (bus.pix_valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                ones++;
                if (bus.underrun !== 1'b0) bad_ur++;
            end
        end
        checks++; if (hs_cnt - hs0 != 2) begin failures++; $display("FAIL b2b_handshakes got=%0d exp=2", hs_cnt - hs0); end
        checks++; if (ones != 16) begin failures++; $display("FAIL b2b_valid_cycles got=%0d exp=16", ones); end
        checks++; if (last - first + 1 != 16) begin failures++; $display("FAIL b2b_span got=%0d exp=16", last - first + 1); end
        checks++; if (bad_ur != 0) begin failures++; $display("FAIL b2b_underrun got=%0d exp=0", bad_ur); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL b2b_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL b2b_bit[%0d] got=%0b exp=%0b", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        int hs0, hs_at8, bad_hold;
        logic prev_bit, prev_vld, prev_rdy;
        new_line(3'd2);
        offer.push_back(4'd3); offer.push_back(4'd5); offer.push_back(4'd6);
        add_exp(4'd3, 3'd2); add_exp(4'd5, 3'd2); add_exp(4'd6, 3'd2);
        hs0 = hs_cnt; hs_at8 = -1; bad_hold = 0;
        prev_bit = 1'b0; prev_vld = 1'b0; prev_rdy = 1'b1;
        for (int c = 0; c < 200 && got.size() < 24; c++) begin
            bus.pix_ready = (c % 2 == 0);
            if (prev_vld && !prev_rdy && (bus.pix_valid !== 1'b1 || bus.pix_bit !== prev_bit)) bad_hold++;
            prev_bit = bus.pix_bit; prev_vld = bus.pix_valid; prev_rdy = bus.pix_ready;
            cyc();
            if (got.size() == 8 && hs_at8 < 0) hs_at8 = hs_cnt - hs0;
        end
        checks++; if (bad_hold != 0) begin failures++; $display("FAIL bp_hold got=%0d exp=0", bad_hold); end
        checks++; if (hs_at8 != 2) begin failures++; $display("FAIL bp_handshakes_at_tile_end got=%0d exp=2", hs_at8); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL bp_len got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL bp_bit[%0d] got=%0b exp=%0b", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [ROW_BITS-1:0] r;
        logic [TILE_BITS-1:0] c;
        int n, errs;
        for (int it = 0; it < 8; it++) begin
            r = ROW_BITS'($urandom_range(0, (1 << ROW_BITS) - 1));
            new_line(r);
            n = $urandom_range(1, 4);
            for (int t = 0; t < n; t++) begin
                c = TILE_BITS'($urandom);
                offer.push_back(c);
                add_exp(c, r);
            end
            for (int k = 0; k < 400 && got.size() < exp.size(); k++) begin
                bus.pix_ready = ($urandom_range(0, 3) != 0);
                cyc();
            end
            errs = 0;
            for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) errs++;
            checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, got.size(), exp.size()); end
            checks++; if (errs != 0) begin failures++; $display("FAIL rand%0d_bits got=%0d wrong exp=0 wrong", it, errs); end
        end
    endtask

    task automatic test_line_start_mid_fetch();
        int bad_vld;
        new_line(3'd2);
        bus.pix_ready = 1'b1;
        offer.push_back(4'd3);
        cyc();
        line_start = 1'b1; row = 3'd0;
        #1;
        checks++; if (bus.tile_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_during got=%0b exp=0", bus.tile_ready); end
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL mid_pix_valid got=%0b exp=0", bus.pix_valid); end
        cyc();
        line_start = 1'b0;
        #1;
        checks++; if (bus.tile_ready !== 1'b1) begin failures++; $display("FAIL mid_ready_after got=%0b exp=1", bus.tile_ready); end
        bad_vld = 0;
        repeat (6) begin cyc(); if (bus.pix_valid !== 1'b0) bad_vld++; end
        checks++; if (bad_vld != 0) begin failures++; $display("FAIL mid_discard got=%0d exp=0", bad_vld); end
        got.delete(); exp.delete();
        offer.push_back(4'd5);
        add_exp(4'd5, 3'd0);
        cyc();
        checks++; if (bus.rom_addr !== 7'h28) begin failures++; $display("FAIL mid_rom_addr got=%0h exp=28", bus.rom_addr); end
        for (int k = 0; k < 30 && got.size() < 8; k++) cyc();
        checks++; if (got.size() != 8) begin failures++; $display("FAIL mid_len got=%0d exp=8", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL mid_bit[%0d] got=%0b exp=%0b", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_simultaneous();
        int hs0;
        new_line(3'd2);
        bus.pix_ready = 1'b1;
        line_start = 1'b1; row = 3'd4;
        offer.push_back(4'd5);
        hs0 = hs_cnt;
        #1;
        checks++; if (bus.tile_ready !== 1'b0) begin failures++; $display("FAIL simul_ready got=%0b exp=0", bus.tile_ready); end
        cyc();
        checks++; if (hs_cnt != hs0) begin failures++; $display("FAIL simul_no_hs got=%0d exp=%0d", hs_cnt, hs0); end
        line_start = 1'b0;
        got.delete(); exp.delete();
        add_exp(4'd5, 3'd4);
        #1;
        checks++; if (bus.tile_ready !== 1'b1) begin failures++; $display("FAIL simul_ready_next got=%0b exp=1", bus.tile_ready); end
        cyc();
        checks++; if (bus.rom_addr !== 7'h2C) begin failures++; $display("FAIL simul_rom_addr got=%0h exp=2c", bus.rom_addr); end
        for (int k = 0; k < 30 && got.size() < 8; k++) cyc();
        checks++; if (got.size() != 8) begin failures++; $display("FAIL simul_len got=%0d exp=8", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL simul_bit[%0d] got=%0b exp=%0b", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_async_reset();
        int bad_vld;
        new_line(3'd2);
        bus.pix_ready = 1'b1;
        offer.push_back(4'd3);
        for (int k = 0; k < 30 && got.size() < 3; k++) cyc();
        checks++; if (got.size() != 3) begin failures++; $display("FAIL areset_setup got=%0d exp=3", got.size()); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL areset_pix_valid got=%0b exp=0", bus.pix_valid); end
        checks++; if (bus.tile_ready !== 1'b0) begin failures++; $display("FAIL areset_tile_ready got=%0b exp=0", bus.tile_ready); end
        checks++; if (bus.rom_addr !== '0) begin failures++; $display("FAIL areset_rom_addr got=%0h exp=0", bus.rom_addr); end
        checks++; if (bus.underrun !== 1'b0) begin failures++; $display("FAIL areset_underrun got=%0b exp=0", bus.underrun); end
        @(negedge clk);
        rst_n = 1'b1;
        offer.delete();
        bad_vld = 0;
        repeat (6) begin cyc(); if (bus.pix_valid !== 1'b0) bad_vld++; end
        checks++; if (bad_vld != 0) begin failures++; $display("FAIL areset_no_partial got=%0d exp=0", bad_vld); end
        new_line(3'd2);
        offer.push_back(4'd5);
        add_exp(4'd5, 3'd2);
        for (int k = 0; k < 30 && got.size() < 8; k++) cyc();
        checks++; if (got.size() != 8) begin failures++; $display("FAIL areset_len got=%0d exp=8", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL areset_bit[%0d] got=%0b exp=%0b", i, got[i], exp[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++) rom_mem[i] = DATA_WIDTH'($urandom);
        rom_mem[7'h1A] = 8'b1011_0010;
        rom_mem[7'h2A] = 8'hFF;
        bus.tile_valid = 1'b0;
        bus.tile_code  = '0;
        bus.pix_ready  = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_single();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_line_start_mid_fetch();
        test_simultaneous();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_fetch_ctrl.md
Name: tile_fetch_ctrl

Overview:
- Sequences the tile ROM (registered read, 1-cycle latency) for the VGA tile renderer.
- Accepts tile codes from the tile-map source over a valid/ready handshake and forms ROM address {tile_code, row}.
- Captures each returned pixel row into a prefetch buffer, then serialises it MSB-first as a 1-bit pixel stream for the colour stage.
- Double-buffered so that back-to-back tiles stream without bubbles.

Parameters:
- ADDR_WIDTH, 7: tile ROM address width. Must match the ROM instance.
- DATA_WIDTH, 8: tile ROM data width, which is also the tile width in pixels.
- ROW_BITS, 3: low address bits that select the row within a tile. Localparam TILE_BITS = ADDR_WIDTH-ROW_BITS.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- line_start  in  1  one-cycle pulse before each active line; flushes the block and latches row.
- row  in  ROW_BITS  row within the tile for the coming line; sampled only on line_start.
- tile_valid  in  1  tile_code is valid.
- tile_ready  out  1  block accepts tile_code this cycle.
- tile_code  in  TILE_BITS  tile index.
- rom_addr  out  ADDR_WIDTH  registered address to the tile ROM.
- rom_rdata  in  DATA_WIDTH  tile ROM read data.
- pix_valid  out  1  pix_bit is valid.
- pix_ready  in  1  downstream consumes pix_bit this cycle.
- pix_bit  out  1  current pixel, MSB of the active row first.
- underrun  out  1  sticky flag; set when pix_ready=1 and pix_valid=0 after the first pixel of a line; cleared by line_start.

Behaviour:
- Reset (asynchronous, rst_n=0) forces all outputs and state to zero:
  - rom_addr=0, tile_ready=0, pix_valid=0, pix_bit=0, underrun=0.
  - FSM=IDLE, row_q=0, next_valid=0, shift count=0, first_seen=0.
- Fetch FSM states:
  - IDLE: tile_ready = !next_valid && !line_start. On tile_valid&&tile_ready: rom_addr <= {tile_code,row_q}, go to ADDR.
  - ADDR: the ROM samples the address this cycle; tile_ready=0; go to DATA.
  - DATA: rom_rdata is valid. next_buf <= rom_rdata, next_valid <= 1, go to IDLE; tile_ready=0.
- Latency: handshake at edge E0 makes rom_addr valid after E0. rom_rdata is valid after E1 and captured at E2. If the shifter is empty, pix_valid rises after E3, i.e. 3 cycles from handshake to first pixel.
- Shifter:
  - 8-bit shift_reg plus a count 0..DATA_WIDTH-1; pix_bit = shift_reg[MSB].
  - Load: when pix_valid=0 (or the last bit is being consumed, i.e. pix_valid&&pix_ready&&count==DATA_WIDTH-1) and next_valid=1, then shift_reg <= next_buf, count <= 0, pix_valid <= 1, next_valid <= 0.
  - Same-cycle load and DATA capture: capture wins the buffer only after the load has consumed it. DATA writes next_buf only when next_valid is 0 after the load in that cycle. Because IDLE gates on !next_valid, a conflict cannot arise; assert this in simulation.
  - On pix_valid&&pix_ready with count<DATA_WIDTH-1: shift left by 1, count+1.
  - Last bit consumed with no next_valid: pix_valid <= 0. This is a bubble, not an error by itself.
  - pix_ready=0 holds pix_bit and count unchanged; there is no wrap of count beyond DATA_WIDTH-1.
- line_start (synchronous, highest priority):
  - row_q <= row; FSM <= IDLE; next_valid <= 0; pix_valid <= 0; count <= 0; underrun <= 0; first_seen <= 0.
  - An in-flight ROM read is discarded; its rom_rdata is ignored.
  - tile_ready is 0 in that cycle, so no handshake completes.
- first_seen sets on the first pix_valid&&pix_ready after line_start. Underrun is tracked only after first_seen=1.
- tile_valid while tile_ready=0: tile_code is held by the source and nothing happens (standard valid/ready; the source must not retract).
- Reset asserted mid-fetch or mid-shift: immediate return to reset values. There is no partial-row output after release.

Decomposition:
- Shared header/package tile_pkg holds:
  - default ROW_BITS/ADDR_WIDTH/DATA_WIDTH;
  - FSM encodings ST_IDLE=2'd0, ST_ADDR=2'd1, ST_DATA=2'd2;
  - TILE_BITS derivation.
- One sub-module is natural: tile_shifter. It holds the load/shift/count/pix_valid logic, with a load port (data, load_en) and a pixel handshake. The FSM, prefetch buffer and underrun logic stay in tile_fetch_ctrl.

Test Plan:
- Single tile, no backpressure. The bench instantiates the team's tile ROM with a test .mem where tile 3 row 2 = 8'b1011_0010. Stimulus: line_start with row=2, handshake tile_code=3, pix_ready=1. Required: rom_addr=7'h1A one cycle later; pix_valid rises 3 cycles after the handshake; pix_bit sequence 1,0,1,1,0,0,1,0; pix_valid falls after 8 pixels; underrun=1 thereafter while pix_ready=1.
- Back-to-back tiles. Stimulus: tiles 3 then 5 (row 2 of tile 5 = 8'hFF) with tile_valid held high. Required: 16 consecutive pix_valid cycles with no gap; bits 10110010 then 11111111; underrun stays 0 until the stream ends.
- Backpressure. Stimulus: pix_ready toggled 1,0,1,0 on tile 3. Required: each bit is held across pix_ready=0 cycles; the bit order is unchanged; tile_ready stays 0 while next_valid=1.
- line_start mid-fetch. Stimulus: line_start asserted in the ADDR state with row=0. Required: the fetched data is discarded, pix_valid=0, tile_ready=0 in that cycle, and tile_ready=1 the next cycle. The next tile fetch uses row 0 (rom_addr = {code,3'b000}).
- Simultaneous line_start and tile_valid. Required: no handshake that cycle; the tile is accepted the next cycle using the new row.
- Asynchronous reset. Stimulus: rst_n asserted during pixel 4 of a row, between clock edges. Required: pix_valid, tile_ready, rom_addr and underrun go to 0 immediately. After release, the first output appears only after a new line_start and fetch.
